// File: rtl/perf_sample_ctrl_if.sv
// perf_sample_ctrl_if: command, event and readback signals of the sampling controller
interface perf_sample_ctrl_if #(
    parameter int NUM_EVT = 4,
    parameter int CNT_W   = 32,
    parameter int WIN_W   = 16
);
    logic               cmd_valid;
    logic [1:0]         cmd_op;
    logic               cmd_ready;
    logic [WIN_W-1:0]   window_len;
    logic [NUM_EVT-1:0] evt_in;
    logic [2:0]         rd_sel;
    logic [CNT_W-1:0]   rd_data;
    logic               sample_valid;
    logic               busy;
    logic [NUM_EVT:0]   ovf;
    modport master (output cmd_valid, cmd_op, window_len, evt_in, rd_sel,
                    input  cmd_ready, rd_data, sample_valid, busy, ovf);
    modport slave  (input  cmd_valid, cmd_op, window_len, evt_in, rd_sel,
                    output cmd_ready, rd_data, sample_valid, busy, ovf);
endinterface

// File: rtl/perf_sample_ctrl.sv
// perf_sample_ctrl: windowed cycle/event counters snapshotted into shadow registers
// at each window end or on STOP, with sticky saturation flags.
module perf_sample_ctrl #(
    parameter int NUM_EVT = 4,
    parameter int CNT_W   = 32,
    parameter int WIN_W   = 16
) (
    input logic               clk,
    input logic               rst,
    perf_sample_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, SNAP} state_t;
    localparam logic [1:0] OP_START = 2'd1, OP_STOP = 2'd2, OP_CLEAR = 2'd3;

    state_t                      state_q, state_d;
    logic [NUM_EVT:0][CNT_W-1:0] live_q, live_d, shad_q, shad_d;
    logic [WIN_W-1:0]            timer_q, timer_d, win_q, win_d;
    logic [NUM_EVT:0]            ovf_q, ovf_d, inc;
    logic                        stop_q, stop_d, sv_q, sv_d, busy_q, busy_d, ready_q, ready_d;
    logic                        acc, acc_start, acc_stop, acc_clear;

    // bit 0 is the cycle counter, which counts every busy cycle
    assign inc       = {bus.evt_in, 1'b1};
    assign acc       = bus.cmd_valid && state_q != SNAP;
    assign acc_start = acc && bus.cmd_op == OP_START;
    assign acc_stop  = acc && bus.cmd_op == OP_STOP;
    assign acc_clear = acc && bus.cmd_op == OP_CLEAR;

    always_comb begin
        state_d = state_q;
        live_d  = live_q;
        shad_d  = shad_q;
        timer_d = timer_q;
        win_d   = win_q;
        ovf_d   = ovf_q;
        stop_d  = stop_q;
        case (state_q)
            IDLE: begin
                if (acc_start) begin
                    win_d   = (bus.window_len == WIN_W'(1)) ? WIN_W'(2) : bus.window_len;
                    timer_d = win_d;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int k = 0; k <= NUM_EVT; k++)
                    if (inc[k]) begin
                        if (&live_q[k]) ovf_d[k] = 1'b1;
                        else live_d[k] = live_q[k] + CNT_W'(1);
                    end
                timer_d = (win_q != '0) ? timer_q - WIN_W'(1) : timer_q;
                if (acc_stop) begin
                    state_d = SNAP;
                    stop_d  = 1'b1;
                end else if (win_q != '0 && timer_q == WIN_W'(1)) state_d = SNAP;
            end
            SNAP: begin
                // the snapshot cycle itself opens the next window
                shad_d = live_q;
                for (int k = 0; k <= NUM_EVT; k++) live_d[k] = CNT_W'(inc[k]);
                if (stop_q) live_d = '0;
                timer_d = win_q - WIN_W'(1);
                state_d = stop_q ? IDLE : RUN;
                stop_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (acc_clear) begin
            live_d  = '0;
            shad_d  = '0;
            timer_d = '0;
            ovf_d   = '0;
            stop_d  = 1'b0;
            state_d = IDLE;
        end
        sv_d    = state_q == SNAP;
        busy_d  = state_d != IDLE;
        ready_d = state_d != SNAP;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            live_q  <= '0;
            shad_q  <= '0;
            timer_q <= '0;
            win_q   <= '0;
            ovf_q   <= '0;
            stop_q  <= 1'b0;
            sv_q    <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            live_q  <= live_d;
            shad_q  <= shad_d;
            timer_q <= timer_d;
            win_q   <= win_d;
            ovf_q   <= ovf_d;
            stop_q  <= stop_d;
            sv_q    <= sv_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end

    assign bus.cmd_ready    = ready_q;
    assign bus.busy         = busy_q;
    assign bus.sample_valid = sv_q;
    assign bus.ovf          = ovf_q;
    assign bus.rd_data      = (bus.rd_sel <= 3'(NUM_EVT)) ? shad_q[bus.rd_sel] : shad_q[0];
endmodule

// File: tb/tb_perf_sample_ctrl.sv
// tb_perf_sample_ctrl: directed scenarios plus randomized commands/events checked
// every cycle against a window-level model of the sampling controller.
module tb_perf_sample_ctrl;
    localparam logic [1:0] NOP = 2'd0, START = 2'd1, STOP = 2'd2, CLEAR = 2'd3;
    localparam int MAXV = 255;

    logic clk = 1'b0, rst = 1'b1;
    int   n_chk = 0, n_pass = 0;
    always #5 clk = ~clk;

    perf_sample_ctrl_if #(.NUM_EVT(4), .CNT_W(8), .WIN_W(16)) b ();
    perf_sample_ctrl_if #(.NUM_EVT(4), .CNT_W(4), .WIN_W(16)) s ();
    perf_sample_ctrl #(.NUM_EVT(4), .CNT_W(8), .WIN_W(16)) dut   (.clk(clk), .rst(rst), .bus(b));
    perf_sample_ctrl #(.NUM_EVT(4), .CNT_W(4), .WIN_W(16)) dut_s (.clk(clk), .rst(rst), .bus(s));

    // model: live/shadow counts as plain ints, window end when elapsed cycles reach the window
    int       live[5] = '{default: 0}, shad[5] = '{default: 0};
    int       el = 0, win = 0;
    bit [4:0] m_ovf = '0;
    bit       m_run = 0, m_stop = 0, m_snap = 0, m_sv = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic m_clear();
        live = '{default: 0};
        shad = '{default: 0};
        m_ovf = '0;
        m_run = 0;
        m_stop = 0;
        el = 0;
    endtask

    task automatic m_step();
        bit acc, nsv;
        acc = b.cmd_valid && !m_snap;
        nsv = m_snap;
        if (m_snap) begin
            shad = live;
            live[0] = 1;
            for (int k = 1; k < 5; k++) live[k] = int'(b.evt_in[k-1]);
            el = 1;
            m_snap = 0;
            if (m_stop) begin
                m_run = 0;
                m_stop = 0;
                live = '{default: 0};
            end
        end else if (m_run) begin
            if (acc && b.cmd_op == CLEAR) m_clear();
            else begin
                for (int k = 0; k < 5; k++)
                    if (k == 0 || b.evt_in[(k == 0) ? 0 : k-1]) begin
                        if (live[k] == MAXV) m_ovf[k] = 1;
                        else live[k]++;
                    end
                el++;
                if (acc && b.cmd_op == STOP) begin
                    m_snap = 1;
                    m_stop = 1;
                end else if (win != 0 && el == win) m_snap = 1;
            end
        end else if (acc && b.cmd_op == START) begin
            m_run = 1;
            win = (b.window_len == 1) ? 2 : int'(b.window_len);
            el = 0;
        end else if (acc && b.cmd_op == CLEAR) m_clear();
        m_sv = nsv;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_clear();
            m_snap = 0;
            m_sv = 0;
        end else m_step();
    end

    always @(negedge clk) begin
        int idx;
        idx = (b.rd_sel <= 4) ? int'(b.rd_sel) : 0;
        chk("cmd_ready", b.cmd_ready, !m_snap);
        chk("busy", b.busy, m_run);
        chk("sample_valid", b.sample_valid, m_sv);
        chk("ovf", b.ovf, m_ovf);
        chk("rd_data", b.rd_data, shad[idx]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(logic [1:0] op);
        b.cmd_valid = 1;
        b.cmd_op = op;
        tick();
        b.cmd_valid = 0;
        b.cmd_op = NOP;
    endtask

    task automatic wait_sv(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (b.sample_valid !== 1'b1 && n < 400);
        if (b.sample_valid !== 1'b1) chk("sample_valid_timeout", 0, 1);
    endtask

    task automatic wait_snap();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (b.cmd_ready !== 1'b0 && k < 50);
        if (b.cmd_ready !== 1'b0) chk("snap_timeout", 0, 1);
    endtask

    task automatic rd_chk(string nm, logic [2:0] sel, int exp);
        b.rd_sel = sel;
        #1;
        chk(nm, b.rd_data, exp);
    endtask

    initial begin
        int n, r, p;
        {b.cmd_valid, b.cmd_op, b.window_len, b.evt_in, b.rd_sel} = '0;
        {s.cmd_valid, s.cmd_op, s.window_len, s.evt_in, s.rd_sel} = '0;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_rd_data", b.rd_data, 0);
        chk("rst_cmd_ready", b.cmd_ready, 1);
        chk("rst_busy", b.busy, 0);
        chk("rst_ovf", b.ovf, 0);
        chk("rst_small_ready", s.cmd_ready, 1);
        tick();
        rst = 0;

        // 8-cycle windows with event 0 always high
        b.window_len = 8;
        b.evt_in = 4'b0001;
        cmd(START);
        wait_sv(n);
        chk("win8_first_latency", n, 10);
        repeat (3) begin
            rd_chk("win8_cycles", 0, 8);
            rd_chk("win8_evt0", 1, 8);
            wait_sv(n);
            chk("win8_period", n, 8);
        end
        tick();
        b.evt_in = 0;
        cmd(STOP);
        wait_sv(n);
        chk("stop_sample_latency", n, 2);
        chk("stop_busy", b.busy, 0);

        // event landing in a snapshot cycle belongs to the next window
        b.window_len = 4;
        cmd(START);
        wait_snap();
        b.evt_in = 4'b0010;
        tick();
        b.evt_in = 0;
        wait_sv(n);
        rd_chk("snap_evt_this", 2, 0);
        wait_sv(n);
        rd_chk("snap_evt_next", 2, 1);
        tick();
        cmd(CLEAR);
        @(negedge clk);
        rd_chk("clear_evt", 2, 0);
        chk("clear_busy", b.busy, 0);

        // free-running for 100 cycles, then STOP in the 101st
        b.window_len = 0;
        cmd(START);
        repeat (100) tick();
        cmd(STOP);
        wait_sv(n);
        chk("free_sample_latency", n, 2);
        rd_chk("free_cycles", 0, 101);
        chk("free_busy", b.busy, 0);

        // STOP held across a snapshot cycle
        b.window_len = 4;
        cmd(START);
        wait_snap();
        b.cmd_valid = 1;
        b.cmd_op = STOP;
        chk("snap_ready", b.cmd_ready, 0);
        @(negedge clk);
        chk("after_snap_ready", b.cmd_ready, 1);
        @(negedge clk);
        chk("stop_snap_ready", b.cmd_ready, 0);
        b.cmd_valid = 0;
        b.cmd_op = NOP;
        wait_sv(n);
        chk("held_stop_latency", n, 1);
        rd_chk("held_stop_cycles", 0, 2);
        chk("held_stop_busy", b.busy, 0);

        // reset during a snapshot cycle
        cmd(START);
        wait_snap();
        #2 rst = 1;
        #1;
        chk("snaprst_sv", b.sample_valid, 0);
        chk("snaprst_busy", b.busy, 0);
        chk("snaprst_ready", b.cmd_ready, 1);
        rd_chk("snaprst_rd", 0, 0);
        @(negedge clk);
        chk("snaprst_sv_late", b.sample_valid, 0);
        @(posedge clk);
        #1 rst = 0;
        cmd(START);
        @(negedge clk);
        chk("post_rst_start", b.busy, 1);
        cmd(CLEAR);

        // 4-bit counters saturate
        s.window_len = 0;
        s.evt_in = 4'b0001;
        s.cmd_valid = 1;
        s.cmd_op = START;
        tick();
        s.cmd_valid = 0;
        repeat (20) tick();
        s.cmd_valid = 1;
        s.cmd_op = STOP;
        tick();
        s.cmd_valid = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (s.sample_valid !== 1'b1 && n < 20);
        chk("sat_sample", s.sample_valid, 1);
        s.rd_sel = 1;
        #1 chk("sat_evt0", s.rd_data, 15);
        s.rd_sel = 0;
        #1 chk("sat_cycles", s.rd_data, 15);
        chk("sat_ovf", s.ovf, 5'b00011);
        tick();
        s.cmd_valid = 1;
        s.cmd_op = CLEAR;
        tick();
        s.cmd_valid = 0;
        @(negedge clk);
        chk("sat_clear_ovf", s.ovf, 0);
        chk("sat_clear_rd", s.rd_data, 0);

        // random traffic: dense commands, then sparse commands for long saturating windows
        for (int c = 0; c < 4000; c++) begin
            p = (c < 2000) ? 30 : 2;
            b.cmd_valid = $urandom_range(99) < p;
            r = $urandom_range(99);
            b.cmd_op = (r < 40) ? START : (r < 55) ? STOP : (r < 65) ? CLEAR : NOP;
            b.window_len = ($urandom_range(9) == 0) ? 16'd300 : 16'($urandom_range(12));
            b.evt_in = 4'($urandom);
            b.rd_sel = 3'($urandom_range(4));
            rst = $urandom_range(999) == 0;
            tick();
        end
        rst = 0;
        b.cmd_valid = 0;
        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
